serial_adder_n: RTL

//  Multi-cycle WIDTH-bit adder/subtractor built from a DIGIT-bit ripple slice of full adders.

---
 rtl/serial_adder_n_if.sv | 38 +++
 rtl/serial_adder_n.sv | 134 +++++++++++++
 2 files changed

// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if
//   Request/result bundle for the multi-cycle serial adder/subtractor.
//   master: drives start/op_sub/ci/a/b and observes busy/done/S/cout/ovf.
//   slave : the adder itself.
//   Signals
//     start   request, accepted only while busy is low
//     op_sub  0: S = a + b + ci, 1: S = a - b
//     ci      carry-in for add mode
//     a, b    WIDTH-bit operands, sampled with an accepted start
//     busy    high while the operation is in progress
//     done    one-cycle pulse when S/cout/ovf are updated
//     S       WIDTH-bit result, held until the next completion
//     cout    carry out of the MSB (subtract: 1 = no borrow)
//     ovf     signed overflow
interface serial_adder_n_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op_sub;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op_sub, ci, a, b,
    input  busy, done, S, cout, ovf
  );

  modport slave (
    input  start, op_sub, ci, a, b,
    output busy, done, S, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// serial_adder_n
//   Multi-cycle WIDTH-bit adder/subtractor. A DIGIT-bit ripple slice of full
//   adders processes one digit per clock, LSB digit first, with the carry held
//   in a register between digits. N = WIDTH/DIGIT cycles from accept to done.
//   Parameters
//     WIDTH  operand/result width (>= 1)
//     DIGIT  bits per cycle; must divide WIDTH
//   Ports
//     clk    rising-edge clock
//     rst    synchronous active-high reset; aborts any operation in progress
//     bus    serial_adder_n_if.slave (start/op_sub/ci/a/b in,
//            busy/done/S/cout/ovf out)
module serial_adder_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_n_if.slave     bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;        // already inverted for subtract
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shadow_q;   // partial result, filled digit by digit
  logic [WIDTH-1:0]   s_q;
  logic               cout_q;
  logic               ovf_q;
  logic               done_q;

  logic               accept;
  logic               step;
  logic               last;

  logic [DIGIT-1:0]   dig_a;
  logic [DIGIT-1:0]   dig_b;
  logic [DIGIT-1:0]   dig_sum;
  logic [DIGIT:0]     c;
  logic [WIDTH-1:0]   shadow_next;

  assign last = (cnt_q == CNT_W'(N - 1));

  // DIGIT-bit ripple slice operating on the current digit.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dig_a       = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    dig_b       = b_q[int'(cnt_q)*DIGIT +: DIGIT];
    dig_sum     = '0;
    c           = '0;
    c[0]        = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = dig_a[i] ^ dig_b[i] ^ c[i];
      c[i+1]     = (dig_a[i] & dig_b[i]) | (c[i] & (dig_a[i] ^ dig_b[i]));
    end
    shadow_next = shadow_q;
    shadow_next[int'(cnt_q)*DIGIT +: DIGIT] = dig_sum;
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // IDLE doubles as the done cycle, so back-to-back starts land here.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= step && last;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b ^ {WIDTH{bus.op_sub}};
        carry_q <= bus.op_sub ? 1'b1 : bus.ci;
        cnt_q   <= '0;
      end
      if (step) begin
        carry_q  <= c[DIGIT];
        shadow_q <= shadow_next;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (last) begin
          // Last digit: c[DIGIT-1] is the carry into bit WIDTH-1.
          s_q    <= shadow_next;
          cout_q <= c[DIGIT];
          ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
